// File: rtl/fft_pkg.sv
// Shared types and constants for the IFFT controller: FSM state encoding,
// stream/audio widths, core config encodings and the 24-bit audio limits.
package fft_pkg;

   localparam int SPEC_W = 32;   // one spectrum component (real or imag)
   localparam int CORE_W = 64;   // core AXI-stream word {imag, real}
   localparam int AUD_W  = 24;   // audio sample written to the FIFO

   // cfg_tdata direction bit understood by the FFT core
   localparam logic CFG_IFFT = 1'b0;
   localparam logic CFG_FFT  = 1'b1;

   // Audio range limits, kept at the shifted-sample width for comparison
   localparam logic signed [SPEC_W-1:0] AUD_MAX = 32'sd8388607;
   localparam logic signed [SPEC_W-1:0] AUD_MIN = -32'sd8388608;

   // Saturated audio codes
   localparam logic [AUD_W-1:0] AUD_POS_SAT = 24'h7F_FFFF;
   localparam logic [AUD_W-1:0] AUD_NEG_SAT = 24'h80_0000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CFG,
      ST_LOAD,
      ST_PAD,
      ST_DRAIN
   } state_e;

endpackage

// File: rtl/ifft_out_narrow.sv
// Output narrowing for the IFFT real part: arithmetic right shift by
// OUT_SHIFT, then reduction to 24 bits, registered with one cycle of latency.
// Build option: define IFFT_OUT_SAT_EN to saturate instead of truncating.
module ifft_out_narrow
   import fft_pkg::*;
#(
   parameter int OUT_SHIFT = 8
)(
   input  logic              clk_50m,
   input  logic              rst,
   input  logic              valid_i,
   input  logic [SPEC_W-1:0] data_i,
   output logic              valid_o,
   output logic [AUD_W-1:0]  data_o
);

   logic signed [SPEC_W-1:0] shifted;
   logic [AUD_W-1:0]         narrow_d;
   logic                     valid_q;
   logic [AUD_W-1:0]         data_q;

   assign shifted = $signed(data_i) >>> OUT_SHIFT;

`ifdef IFFT_OUT_SAT_EN
   // Clamp out-of-range samples to the nearest representable audio code.
   always_comb begin
      narrow_d = shifted[AUD_W-1:0];
      if (shifted > AUD_MAX) begin
         narrow_d = AUD_POS_SAT;
      end else if (shifted < AUD_MIN) begin
         narrow_d = AUD_NEG_SAT;
      end
   end
`else
   // Keep only the low 24 bits; large samples wrap around.
   logic unused_shift_hi;
   assign unused_shift_hi = ^shifted[SPEC_W-1:AUD_W];

   always_comb begin
      narrow_d = shifted[AUD_W-1:0];
   end
`endif

   // Register the narrowed sample; a dropped beat leaves the last data in place.
   always_ff @(posedge clk_50m or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_i;
         if (valid_i) begin
            data_q <= narrow_d;
         end
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/ifft_ctrl.sv
// IFFT frame controller: accepts spectrum frames, configures the FFT core for
// inverse mode, streams FFT_LEN points into it (zero-padding short frames) and
// narrows the core's real output into an audio FIFO.
// Build option: define IFFT_OUT_SAT_EN to saturate audio samples (default wraps).
module ifft_ctrl
   import fft_pkg::*;
#(
   parameter int FFT_LEN   = 1024,
   parameter int OUT_SHIFT = 8
)(
   input  logic              clk_50m,
   input  logic              rst,
   // spectrum sink
   input  logic              spec_valid,
   input  logic              spec_sop,
   input  logic              spec_eop,
   input  logic [SPEC_W-1:0] spec_real,
   input  logic [SPEC_W-1:0] spec_imag,
   output logic              spec_ready,
   // core config and data input
   output logic              cfg_tvalid,
   output logic              cfg_tdata,
   output logic              data_tvalid,
   output logic [CORE_W-1:0] data_tdata,
   output logic              data_tlast,
   input  logic              data_tready,
   // core output
   input  logic              core_tvalid,
   input  logic [CORE_W-1:0] core_tdata,
   input  logic              core_tlast,
   // audio FIFO and status
   output logic              fifo_wrreq,
   output logic [AUD_W-1:0]  fifo_wdata,
   input  logic              fifo_full,
   output logic              ovf_flag,
   output logic              busy
);

   localparam int               CNT_W    = $clog2(FFT_LEN);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FFT_LEN - 1);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             cfg_tvalid_q;
   logic             busy_q;
   logic             ovf_q;
   logic             sop_block;
   logic             beat_xfer;
   logic             last_beat;
   logic             core_wr;
   logic             unused_core_imag;

   assign last_beat = (cnt_q == LAST_IDX);

   // Input handshake: live pass-through while loading, zero beats while padding.
   always_comb begin
      spec_ready  = 1'b0;
      data_tvalid = 1'b0;
      data_tdata  = '0;
      data_tlast  = 1'b0;
      sop_block   = 1'b0;
      beat_xfer   = 1'b0;
      case (state_q)
         ST_LOAD: begin
            // A fresh sop after the first beat belongs to the next frame: hold it off.
            sop_block   = spec_valid & spec_sop & (cnt_q != '0);
            spec_ready  = data_tready & ~sop_block;
            data_tvalid = spec_valid & ~sop_block;
            data_tdata  = {spec_imag, spec_real};
            data_tlast  = data_tvalid & last_beat;
            beat_xfer   = data_tvalid & data_tready;
         end
         ST_PAD: begin
            data_tvalid = 1'b1;
            data_tlast  = last_beat;
            beat_xfer   = data_tready;
         end
         default: begin
         end
      endcase
   end

   // Frame sequencing with registered config pulse and busy flag.
   always_ff @(posedge clk_50m or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         cfg_tvalid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         cfg_tvalid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               // The sop sample stays on the bus and is consumed in LOAD.
               if (spec_valid && spec_sop) begin
                  state_q      <= ST_CFG;
                  cfg_tvalid_q <= 1'b1;
                  busy_q       <= 1'b1;
               end
            end
            ST_CFG: begin
               state_q <= ST_LOAD;
               cnt_q   <= '0;
            end
            ST_LOAD: begin
               if (sop_block) begin
                  state_q <= ST_PAD;
               end else if (beat_xfer) begin
                  if (last_beat) begin
                     state_q <= ST_DRAIN;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                     if (spec_eop) begin
                        state_q <= ST_PAD;
                     end
                  end
               end
            end
            ST_PAD: begin
               if (beat_xfer) begin
                  if (last_beat) begin
                     state_q <= ST_DRAIN;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            ST_DRAIN: begin
               if (core_tvalid && core_tlast) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign cfg_tvalid = cfg_tvalid_q;
   assign cfg_tdata  = cfg_tvalid_q ? CFG_IFFT : 1'b0;
   assign busy       = busy_q;

   // Core output is written in any state, since the core overlaps frames.
   assign core_wr          = core_tvalid & ~fifo_full;
   assign unused_core_imag = ^core_tdata[CORE_W-1:SPEC_W];

   ifft_out_narrow #(
      .OUT_SHIFT (OUT_SHIFT)
   ) u_narrow (
      .clk_50m (clk_50m),
      .rst     (rst),
      .valid_i (core_wr),
      .data_i  (core_tdata[SPEC_W-1:0]),
      .valid_o (fifo_wrreq),
      .data_o  (fifo_wdata)
   );

   // Sticky overflow: any core beat that meets a full FIFO is lost.
   always_ff @(posedge clk_50m or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (core_tvalid && fifo_full) begin
         ovf_q <= 1'b1;
      end
   end

   assign ovf_flag = ovf_q;

endmodule

// File: tb/tb_ifft_ctrl.sv
// Directed testbench for ifft_ctrl with FFT_LEN=8, OUT_SHIFT=0.
// Expectations for the narrowing path follow IFFT_OUT_SAT_EN.
module tb_ifft_ctrl;

   logic        clk_50m = 1'b0;
   logic        rst = 1'b1;
   logic        spec_valid = 1'b0, spec_sop = 1'b0, spec_eop = 1'b0;
   logic [31:0] spec_real = '0, spec_imag = '0;
   logic        spec_ready;
   logic        cfg_tvalid, cfg_tdata, data_tvalid, data_tlast;
   logic [63:0] data_tdata;
   logic        data_tready = 1'b0;
   logic        core_tvalid = 1'b0, core_tlast = 1'b0;
   logic [63:0] core_tdata = '0;
   logic        fifo_wrreq;
   logic [23:0] fifo_wdata;
   logic        fifo_full = 1'b0;
   logic        ovf_flag, busy;

   int n_cmp = 0;
   int n_bad = 0;

   ifft_ctrl #(.FFT_LEN(8), .OUT_SHIFT(0)) dut (
      .clk_50m(clk_50m), .rst(rst),
      .spec_valid(spec_valid), .spec_sop(spec_sop), .spec_eop(spec_eop),
      .spec_real(spec_real), .spec_imag(spec_imag), .spec_ready(spec_ready),
      .cfg_tvalid(cfg_tvalid), .cfg_tdata(cfg_tdata),
      .data_tvalid(data_tvalid), .data_tdata(data_tdata), .data_tlast(data_tlast),
      .data_tready(data_tready),
      .core_tvalid(core_tvalid), .core_tdata(core_tdata), .core_tlast(core_tlast),
      .fifo_wrreq(fifo_wrreq), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full),
      .ovf_flag(ovf_flag), .busy(busy)
   );

   always #10 clk_50m = ~clk_50m;

   function automatic logic [63:0] beat_data(input int idx);
      logic [31:0] re, im;
      re = 32'h0100_0000 + 32'(idx);
      im = 32'hA000_0000 - 32'(idx);
      return {im, re};
   endfunction

   task automatic drive_spec(input logic v, input logic s, input logic e, input int idx);
      spec_valid = v;
      spec_sop   = s;
      spec_eop   = e;
      {spec_imag, spec_real} = beat_data(idx);
   endtask

   task automatic next_cycle();
      @(posedge clk_50m);
      #1;
   endtask

   task automatic mid();
      @(negedge clk_50m);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive_spec(1'b1, 1'b1, 1'b0, 5);
      data_tready = 1'b1;
      core_tvalid = 1'b1;
      fifo_full   = 1'b1;
      repeat (2) next_cycle();
      mid();
      n_cmp++;
      if ({spec_ready, cfg_tvalid, cfg_tdata, data_tvalid, data_tlast, fifo_wrreq, ovf_flag, busy} !== 8'h00) begin
         n_bad++;
         $display("FAIL reset_flags: got %b want 00000000",
                  {spec_ready, cfg_tvalid, cfg_tdata, data_tvalid, data_tlast, fifo_wrreq, ovf_flag, busy});
      end
      n_cmp++;
      if ({data_tdata, fifo_wdata} !== 88'h0) begin
         n_bad++;
         $display("FAIL reset_data: got tdata=%h wdata=%h want 0", data_tdata, fifo_wdata);
      end
      next_cycle();
      rst = 1'b0;
      drive_spec(1'b0, 1'b0, 1'b0, 0);
      core_tvalid = 1'b0;
      fifo_full   = 1'b0;
      $display("reset: outputs checked during reset");
   endtask

   task automatic test_full_frame();
      int rdy_cnt = 0;
      next_cycle();
      data_tready = 1'b1;
      drive_spec(1'b1, 1'b1, 1'b0, 0);
      mid();
      n_cmp++;
      if ({spec_ready, cfg_tvalid, busy} !== 3'b000) begin
         n_bad++;
         $display("FAIL full_idle: got ready/cfg/busy=%b want 000", {spec_ready, cfg_tvalid, busy});
      end
      next_cycle();
      mid();
      n_cmp++;
      if ({cfg_tvalid, cfg_tdata, busy, spec_ready, data_tvalid} !== 5'b10100) begin
         n_bad++;
         $display("FAIL full_cfg: got cfg/cdata/busy/ready/dvalid=%b want 10100",
                  {cfg_tvalid, cfg_tdata, busy, spec_ready, data_tvalid});
      end
      for (int b = 0; b < 8; b++) begin
         next_cycle();
         drive_spec(1'b1, b == 0, b == 7, b);
         mid();
         if (spec_ready === 1'b1) rdy_cnt++;
         n_cmp++;
         if ({spec_ready, data_tvalid, data_tlast, cfg_tvalid} !== {1'b1, 1'b1, logic'(b == 7), 1'b0}) begin
            n_bad++;
            $display("FAIL full_beat%0d_ctl: got ready/valid/last/cfg=%b want %b", b,
                     {spec_ready, data_tvalid, data_tlast, cfg_tvalid}, {1'b1, 1'b1, logic'(b == 7), 1'b0});
         end
         n_cmp++;
         if (data_tdata !== beat_data(b)) begin
            n_bad++;
            $display("FAIL full_beat%0d_data: got %h want %h", b, data_tdata, beat_data(b));
         end
      end
      next_cycle();
      drive_spec(1'b0, 1'b0, 1'b0, 0);
      mid();
      n_cmp++;
      if ({spec_ready, data_tvalid, busy} !== 3'b001) begin
         n_bad++;
         $display("FAIL full_drain: got ready/valid/busy=%b want 001", {spec_ready, data_tvalid, busy});
      end
      n_cmp++;
      if (rdy_cnt !== 8) begin
         n_bad++;
         $display("FAIL full_ready_cycles: got %0d want 8", rdy_cnt);
      end
      $display("full_frame: 8 beats streamed, ready cycles=%0d", rdy_cnt);
   endtask

   task automatic test_drain();
      logic [31:0] re_v [4];
      logic [23:0] exp_v [4];
      re_v[0] = 32'h0000_1234; re_v[1] = 32'hFFFF_FFF0;
      re_v[2] = 32'h7FFF_FFFF; re_v[3] = 32'h8000_0000;
      exp_v[0] = 24'h00_1234;  exp_v[1] = 24'hFF_FFF0;
`ifdef IFFT_OUT_SAT_EN
      exp_v[2] = 24'h7F_FFFF;  exp_v[3] = 24'h80_0000;
`else
      exp_v[2] = 24'hFF_FFFF;  exp_v[3] = 24'h00_0000;
`endif
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         core_tvalid = 1'b1;
         core_tlast  = (i == 3);
         core_tdata  = {32'hDEAD_BEEF, re_v[i]};
         mid();
         n_cmp++;
         if (i == 0) begin
            if ({fifo_wrreq, busy} !== 2'b01) begin
               n_bad++;
               $display("FAIL drain_first: got wrreq/busy=%b want 01", {fifo_wrreq, busy});
            end
         end else if ({fifo_wrreq, fifo_wdata, busy} !== {1'b1, exp_v[i-1], 1'b1}) begin
            n_bad++;
            $display("FAIL drain_beat%0d: got wrreq=%b wdata=%h busy=%b want 1 %h 1", i - 1,
                     fifo_wrreq, fifo_wdata, busy, exp_v[i-1]);
         end
      end
      next_cycle();
      core_tvalid = 1'b0;
      core_tlast  = 1'b0;
      mid();
      n_cmp++;
      if ({fifo_wrreq, fifo_wdata, busy} !== {1'b1, exp_v[3], 1'b0}) begin
         n_bad++;
         $display("FAIL drain_last: got wrreq=%b wdata=%h busy=%b want 1 %h 0",
                  fifo_wrreq, fifo_wdata, busy, exp_v[3]);
      end
      next_cycle();
      mid();
      n_cmp++;
      if ({fifo_wrreq, ovf_flag} !== 2'b00) begin
         n_bad++;
         $display("FAIL drain_quiet: got wrreq/ovf=%b want 00", {fifo_wrreq, ovf_flag});
      end
      $display("drain: 4 core beats narrowed, last wdata=%h", fifo_wdata);
   endtask

   task automatic test_eop_pad();
      next_cycle();
      data_tready = 1'b1;
      drive_spec(1'b1, 1'b1, 1'b0, 10);
      mid();
      next_cycle();
      mid();
      n_cmp++;
      if (cfg_tvalid !== 1'b1) begin
         n_bad++;
         $display("FAIL pad_cfg: got %b want 1", cfg_tvalid);
      end
      for (int b = 0; b < 5; b++) begin
         next_cycle();
         drive_spec(1'b1, b == 0, b == 4, 10 + b);
         mid();
         n_cmp++;
         if ({spec_ready, data_tvalid, data_tlast, data_tdata} !== {3'b110, beat_data(10 + b)}) begin
            n_bad++;
            $display("FAIL pad_load%0d: got ctl=%b data=%h want 110 %h", b,
                     {spec_ready, data_tvalid, data_tlast}, data_tdata, beat_data(10 + b));
         end
      end
      for (int b = 5; b < 8; b++) begin
         next_cycle();
         drive_spec(1'b0, 1'b0, 1'b0, 99);
         mid();
         n_cmp++;
         if ({spec_ready, data_tvalid, data_tlast, busy, data_tdata} !== {1'b0, 1'b1, logic'(b == 7), 1'b1, 64'h0}) begin
            n_bad++;
            $display("FAIL pad_zero%0d: got ready/valid/last/busy=%b data=%h want 01%b1 0", b,
                     {spec_ready, data_tvalid, data_tlast, busy}, data_tdata, logic'(b == 7));
         end
      end
      next_cycle();
      core_tvalid = 1'b1;
      core_tlast  = 1'b1;
      core_tdata  = {32'h0, 32'h0000_0100};
      mid();
      n_cmp++;
      if ({spec_ready, data_tvalid, busy} !== 3'b001) begin
         n_bad++;
         $display("FAIL pad_drain: got ready/valid/busy=%b want 001", {spec_ready, data_tvalid, busy});
      end
      next_cycle();
      core_tvalid = 1'b0;
      core_tlast  = 1'b0;
      mid();
      n_cmp++;
      if ({busy, fifo_wrreq, fifo_wdata} !== {2'b01, 24'h00_0100}) begin
         n_bad++;
         $display("FAIL pad_idle: got busy=%b wrreq=%b wdata=%h want 0 1 000100", busy, fifo_wrreq, fifo_wdata);
      end
      $display("eop_pad: eop at beat 4, beats 5..7 padded");
   endtask

   task automatic test_tready_toggle();
      int b = 0;
      next_cycle();
      data_tready = 1'b0;
      drive_spec(1'b1, 1'b1, 1'b0, 20);
      mid();
      next_cycle();
      mid();
      n_cmp++;
      if (cfg_tvalid !== 1'b1) begin
         n_bad++;
         $display("FAIL tog_cfg: got %b want 1", cfg_tvalid);
      end
      for (int cyc = 0; cyc < 16; cyc++) begin
         next_cycle();
         data_tready = logic'(cyc % 2);
         drive_spec(1'b1, b == 0, b == 7, 20 + b);
         mid();
         n_cmp++;
         if ({spec_ready, data_tvalid, data_tlast, data_tdata} !==
             {data_tready, 1'b1, logic'(b == 7), beat_data(20 + b)}) begin
            n_bad++;
            $display("FAIL tog_cyc%0d: got ready/valid/last=%b data=%h want %b1%b %h", cyc,
                     {spec_ready, data_tvalid, data_tlast}, data_tdata, data_tready, logic'(b == 7),
                     beat_data(20 + b));
         end
         if (data_tready) b++;
      end
      next_cycle();
      data_tready = 1'b1;
      drive_spec(1'b0, 1'b0, 1'b0, 0);
      mid();
      n_cmp++;
      if ({spec_ready, data_tvalid, busy} !== 3'b001) begin
         n_bad++;
         $display("FAIL tog_drain: got ready/valid/busy=%b want 001", {spec_ready, data_tvalid, busy});
      end
      next_cycle();
      core_tvalid = 1'b1;
      core_tlast  = 1'b1;
      next_cycle();
      core_tvalid = 1'b0;
      core_tlast  = 1'b0;
      mid();
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL tog_idle: got busy=%b want 0", busy);
      end
      $display("tready_toggle: 8 beats in 16 cycles");
   endtask

   task automatic test_fifo_full();
      logic fpat [5];
      int   wr_cnt = 0;
      fpat[0] = 1'b0; fpat[1] = 1'b1; fpat[2] = 1'b1; fpat[3] = 1'b1; fpat[4] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         next_cycle();
         core_tvalid = 1'b1;
         core_tlast  = 1'b0;
         fifo_full   = fpat[i];
         core_tdata  = {32'h0, 32'h100 * 32'(i + 1)};
         mid();
         if (fifo_wrreq === 1'b1) wr_cnt++;
         if (i > 0) begin
            n_cmp++;
            if ({fifo_wrreq, ovf_flag, busy} !== {~fpat[i-1], logic'(i >= 2), 1'b0}) begin
               n_bad++;
               $display("FAIL full_cyc%0d: got wrreq/ovf/busy=%b want %b%b0", i,
                        {fifo_wrreq, ovf_flag, busy}, ~fpat[i-1], logic'(i >= 2));
            end
         end
      end
      next_cycle();
      core_tvalid = 1'b0;
      fifo_full   = 1'b0;
      mid();
      if (fifo_wrreq === 1'b1) wr_cnt++;
      n_cmp++;
      if ({fifo_wrreq, fifo_wdata, ovf_flag} !== {1'b1, 24'h00_0500, 1'b1}) begin
         n_bad++;
         $display("FAIL full_last: got wrreq=%b wdata=%h ovf=%b want 1 000500 1", fifo_wrreq, fifo_wdata, ovf_flag);
      end
      n_cmp++;
      if (wr_cnt !== 2) begin
         n_bad++;
         $display("FAIL full_wr_count: got %0d want 2", wr_cnt);
      end
      repeat (3) next_cycle();
      mid();
      n_cmp++;
      if ({ovf_flag, fifo_wrreq} !== 2'b10) begin
         n_bad++;
         $display("FAIL full_sticky: got ovf/wrreq=%b want 10", {ovf_flag, fifo_wrreq});
      end
      next_cycle();
      rst = 1'b1;
      mid();
      n_cmp++;
      if (ovf_flag !== 1'b0) begin
         n_bad++;
         $display("FAIL full_ovf_clear: got %b want 0", ovf_flag);
      end
      next_cycle();
      rst = 1'b0;
      $display("fifo_full: writes=%0d of 5, overflow cleared by reset", wr_cnt);
   endtask

   task automatic test_sop_midframe();
      next_cycle();
      data_tready = 1'b1;
      drive_spec(1'b1, 1'b1, 1'b0, 30);
      mid();
      next_cycle();
      mid();
      for (int b = 0; b < 3; b++) begin
         next_cycle();
         drive_spec(1'b1, b == 0, 1'b0, 30 + b);
         mid();
         n_cmp++;
         if ({spec_ready, data_tvalid, data_tdata} !== {2'b11, beat_data(30 + b)}) begin
            n_bad++;
            $display("FAIL sop_load%0d: got ready/valid=%b data=%h want 11 %h", b,
                     {spec_ready, data_tvalid}, data_tdata, beat_data(30 + b));
         end
      end
      next_cycle();
      drive_spec(1'b1, 1'b1, 1'b0, 40);
      mid();
      n_cmp++;
      if ({spec_ready, data_tvalid} !== 2'b00) begin
         n_bad++;
         $display("FAIL sop_block: got ready/valid=%b want 00", {spec_ready, data_tvalid});
      end
      for (int b = 3; b < 8; b++) begin
         next_cycle();
         mid();
         n_cmp++;
         if ({spec_ready, data_tvalid, data_tlast, data_tdata} !== {1'b0, 1'b1, logic'(b == 7), 64'h0}) begin
            n_bad++;
            $display("FAIL sop_pad%0d: got ready/valid/last=%b data=%h want 01%b 0", b,
                     {spec_ready, data_tvalid, data_tlast}, data_tdata, logic'(b == 7));
         end
      end
      next_cycle();
      core_tvalid = 1'b1;
      core_tlast  = 1'b1;
      mid();
      n_cmp++;
      if ({spec_ready, busy} !== 2'b01) begin
         n_bad++;
         $display("FAIL sop_drain: got ready/busy=%b want 01", {spec_ready, busy});
      end
      next_cycle();
      core_tvalid = 1'b0;
      core_tlast  = 1'b0;
      mid();
      n_cmp++;
      if ({busy, cfg_tvalid, spec_ready} !== 3'b000) begin
         n_bad++;
         $display("FAIL sop_idle: got busy/cfg/ready=%b want 000", {busy, cfg_tvalid, spec_ready});
      end
      next_cycle();
      mid();
      n_cmp++;
      if (cfg_tvalid !== 1'b1) begin
         n_bad++;
         $display("FAIL sop_next_cfg: got %b want 1", cfg_tvalid);
      end
      $display("sop_midframe: frame closed by padding, held sop restarted a frame");
   endtask

   task automatic test_reset_midframe();
      for (int b = 0; b < 4; b++) begin
         next_cycle();
         drive_spec(1'b1, b == 0, 1'b0, 40 + b);
         mid();
         n_cmp++;
         if ({spec_ready, data_tdata} !== {1'b1, beat_data(40 + b)}) begin
            n_bad++;
            $display("FAIL rstmid_load%0d: got ready=%b data=%h want 1 %h", b, spec_ready, data_tdata,
                     beat_data(40 + b));
         end
      end
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({spec_ready, cfg_tvalid, cfg_tdata, data_tvalid, data_tlast, fifo_wrreq, ovf_flag, busy, data_tdata, fifo_wdata} !== 96'h0) begin
         n_bad++;
         $display("FAIL rstmid_async: got flags=%b data=%h wdata=%h want all 0",
                  {spec_ready, cfg_tvalid, cfg_tdata, data_tvalid, data_tlast, fifo_wrreq, ovf_flag, busy},
                  data_tdata, fifo_wdata);
      end
      next_cycle();
      mid();
      n_cmp++;
      if ({data_tvalid, data_tlast, busy} !== 3'b000) begin
         n_bad++;
         $display("FAIL rstmid_hold: got valid/last/busy=%b want 000", {data_tvalid, data_tlast, busy});
      end
      next_cycle();
      rst = 1'b0;
      drive_spec(1'b0, 1'b0, 1'b0, 0);
      next_cycle();
      drive_spec(1'b1, 1'b1, 1'b0, 50);
      mid();
      n_cmp++;
      if ({cfg_tvalid, spec_ready, busy} !== 3'b000) begin
         n_bad++;
         $display("FAIL rstmid_idle: got cfg/ready/busy=%b want 000", {cfg_tvalid, spec_ready, busy});
      end
      next_cycle();
      mid();
      n_cmp++;
      if ({cfg_tvalid, cfg_tdata, busy} !== 3'b101) begin
         n_bad++;
         $display("FAIL rstmid_cfg: got cfg/cdata/busy=%b want 101", {cfg_tvalid, cfg_tdata, busy});
      end
      next_cycle();
      mid();
      n_cmp++;
      if ({cfg_tvalid, spec_ready, data_tdata} !== {2'b01, beat_data(50)}) begin
         n_bad++;
         $display("FAIL rstmid_load: got cfg/ready=%b data=%h want 01 %h", {cfg_tvalid, spec_ready},
                  data_tdata, beat_data(50));
      end
      $display("reset_midframe: partial frame abandoned, fresh cfg pulse seen");
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_drain();
      test_eop_pad();
      test_tready_toggle();
      test_fifo_full();
      test_sop_midframe();
      test_reset_midframe();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
